// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed 7-segment display driver.
//
// Scans NUM_DIGITS common-anode digits, one slot of REFRESH_DIV clocks each.
// Every slot begins with one dead-time cycle where all anodes are off.
// A loaded value waits in a shadow register and becomes visible only at a
// frame wrap, so a frame never mixes old and new digits.
// All display outputs are registered from the previous cycle's state.
//
// Build option: define SEG7_HEX_EN to decode codes 10..15 as A b C d E F.
// Without it, those codes show the same pattern as 0.
// Leading-zero blanking only treats code 0 as zero, in both builds.
module seg7_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [4*NUM_DIGITS-1:0] i_value,
    input  logic [NUM_DIGITS-1:0]   i_dp,
    input  logic                    i_load,
    input  logic                    i_lzb,
    output logic [NUM_DIGITS-1:0]   o_anode,
    output logic [6:0]              o_segment,
    output logic                    o_dp,
    output logic                    o_frame,
    output logic                    o_busy
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    // Segment patterns, bit order g..a, active-low
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    // Active-low decode of one code; out-of-table codes look like 0
    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
`ifdef SEG7_HEX_EN
            4'd10:   s = 7'b0001000;
            4'd11:   s = 7'b0000011;
            4'd12:   s = 7'b1000110;
            4'd13:   s = 7'b0100001;
            4'd14:   s = 7'b0000110;
            4'd15:   s = 7'b0001110;
`endif
            default: s = SEG_ZERO;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]                cnt_q,        cnt_d;
    logic [IDX_W-1:0]                idx_q,        idx_d;
    logic                            pend_q,       pend_d;
    logic [NUM_DIGITS-1:0][3:0]      shadow_val_q, shadow_val_d;
    logic [NUM_DIGITS-1:0]           shadow_dp_q,  shadow_dp_d;
    logic [NUM_DIGITS-1:0][3:0]      act_val_q,    act_val_d;
    logic [NUM_DIGITS-1:0]           act_dp_q,     act_dp_d;

    logic [NUM_DIGITS-1:0]           anode_q,      anode_d;
    logic [6:0]                      seg_q,        seg_d;
    logic                            dp_q,         dp_d;
    logic                            frame_q,      frame_d;

    logic tick;
    logic wrap;

    assign tick = (cnt_q == CNT_LAST);
    // With one digit idx is pinned at 0, so every tick is a wrap
    assign wrap = tick && (idx_q == IDX_LAST);

    // Prescaler and digit index advance
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (tick) begin
            cnt_d = '0;
            idx_d = wrap ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Shadow/active double buffer: loads park in shadow, commit on wrap.
    // A load landing exactly on the wrap edge skips the shadow wait.
    always_comb begin
        pend_d       = pend_q;
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        act_val_d    = act_val_q;
        act_dp_d     = act_dp_q;
        if (i_load) begin
            shadow_val_d = i_value;
            shadow_dp_d  = i_dp;
        end
        if (wrap) begin
            if (i_load) begin
                act_val_d = i_value;
                act_dp_d  = i_dp;
            end else if (pend_q) begin
                act_val_d = shadow_val_q;
                act_dp_d  = shadow_dp_q;
            end
            pend_d = 1'b0;
        end else if (i_load) begin
            pend_d = 1'b1;
        end
    end

    // upper_zero[k]: active digits k..NUM_DIGITS-1 are all code 0
    logic [NUM_DIGITS-1:0] upper_zero;

    // Leading-zero chain, built from the most significant digit downwards
    always_comb begin
        upper_zero = '0;
        upper_zero[NUM_DIGITS-1] = (act_val_q[NUM_DIGITS-1] == 4'd0);
        for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
            upper_zero[k] = upper_zero[k+1] && (act_val_q[k] == 4'd0);
        end
    end

    logic       blank_cur;
    logic [3:0] code_cur;

    assign code_cur  = act_val_q[idx_q];
    // Digit 0 always shows, so "0" is displayed for an all-zero value
    assign blank_cur = i_lzb && (idx_q != '0) && upper_zero[idx_q];

    // Next display outputs from the current scan position and active value
    always_comb begin
        anode_d = (cnt_q == '0) ? '1 : ~(NUM_DIGITS'(1) << idx_q);
        seg_d   = blank_cur ? SEG_BLANK : decode(code_cur);
        dp_d    = blank_cur ? 1'b1 : ~act_dp_q[idx_q];
        frame_d = wrap;
    end

    // State and output registers, synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            pend_q       <= 1'b0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            act_val_q    <= '0;
            act_dp_q     <= '0;
            anode_q      <= '1;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
            frame_q      <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pend_q       <= pend_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            act_val_q    <= act_val_d;
            act_dp_q     <= act_dp_d;
            anode_q      <= anode_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_q      <= frame_d;
        end
    end

    assign o_anode   = anode_q;
    assign o_segment = seg_q;
    assign o_dp      = dp_q;
    assign o_frame   = frame_q;
    // Busy is the pending flag itself, already a register
    assign o_busy    = pend_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (NUM_DIGITS=4, REFRESH_DIV=4).
// A frame-position reference model predicts every output cycle and queues it;
// a monitor on the falling edge pops and compares.
module tb_seg7_scan_driver;

    localparam int N     = 4;
    localparam int DIV   = 4;
    localparam int FRAME = N * DIV;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [4*N-1:0] value;
    logic [N-1:0]   dp_in;
    logic           load;
    logic           lzb;
    logic [N-1:0]   anode;
    logic [6:0]     seg;
    logic           dp_out;
    logic           frame;
    logic           busy;

    always #5 clk = ~clk;

    seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(DIV)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_value   (value),
        .i_dp      (dp_in),
        .i_load    (load),
        .i_lzb     (lzb),
        .o_anode   (anode),
        .o_segment (seg),
        .o_dp      (dp_out),
        .o_frame   (frame),
        .o_busy    (busy)
    );

    typedef struct {
        logic [N-1:0] anode;
        logic [6:0]   seg;
        logic         dp;
        logic         frame;
        logic         busy;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: position within the frame plus digit arrays
    int m_phase = 0;
    int m_act[N];
    bit m_act_dp[N];
    int m_sh[N];
    bit m_sh_dp[N];
    bit m_pend = 0;

    function automatic logic [6:0] ref_seg(input int code);
        case (code)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
`ifdef SEG7_HEX_EN
            10: return 7'b0001000;
            11: return 7'b0000011;
            12: return 7'b1000110;
            13: return 7'b0100001;
            14: return 7'b0000110;
            15: return 7'b0001110;
`endif
            default: return 7'b1000000;
        endcase
    endfunction

    // Model: predict the outputs that appear after this rising edge
    initial begin
        for (int i = 0; i < N; i++) begin
            m_act[i] = 0; m_act_dp[i] = 0; m_sh[i] = 0; m_sh_dp[i] = 0;
        end
        forever begin
            exp_t e;
            @(posedge clk);
            if (rst_n !== 1'b1) begin
                e.anode = '1; e.seg = 7'h7f; e.dp = 1'b1; e.frame = 1'b0; e.busy = 1'b0;
                m_phase = 0;
                m_pend  = 0;
                for (int i = 0; i < N; i++) begin
                    m_act[i] = 0; m_act_dp[i] = 0; m_sh[i] = 0; m_sh_dp[i] = 0;
                end
            end else begin
                int  slot;
                int  sub;
                bit  all_zero;
                bit  blank;
                bit  at_wrap;
                slot = m_phase / DIV;
                sub  = m_phase % DIV;
                all_zero = 1;
                for (int j = slot; j < N; j++) if (m_act[j] != 0) all_zero = 0;
                blank = lzb && (slot > 0) && all_zero;
                e.anode = (sub == 0) ? '1 : ~(N'(1) << slot);
                e.seg   = blank ? 7'h7f : ref_seg(m_act[slot]);
                e.dp    = blank ? 1'b1 : !m_act_dp[slot];
                at_wrap = (m_phase == FRAME - 1);
                e.frame = at_wrap;
                if (at_wrap) begin
                    for (int i = 0; i < N; i++) begin
                        if (load) begin
                            m_act[i] = int'(value[4*i +: 4]); m_act_dp[i] = dp_in[i];
                        end else if (m_pend) begin
                            m_act[i] = m_sh[i]; m_act_dp[i] = m_sh_dp[i];
                        end
                    end
                    m_pend = 0;
                end else if (load) begin
                    for (int i = 0; i < N; i++) begin
                        m_sh[i] = int'(value[4*i +: 4]); m_sh_dp[i] = dp_in[i];
                    end
                    m_pend = 1;
                end
                e.busy  = m_pend;
                m_phase = (m_phase + 1) % FRAME;
            end
            exp_q.push_back(e);
        end
    end

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s t=%0t got=%b expected=%b", name, $time, act, expv);
        end
    endtask

    task automatic chk7(input string name, input logic [6:0] act, input logic [6:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s t=%0t got=%b expected=%b", name, $time, act, expv);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("anode", anode, e.anode);
                chk7("segment", seg, e.seg);
                chk("dp", N'(dp_out), N'(e.dp));
                chk("frame", N'(frame), N'(e.frame));
                chk("busy", N'(busy), N'(e.busy));
            end
        end
    end

    // Wait (on falling edges) until the next rising edge sits at frame position p
    task automatic wait_phase(input int p);
        bit hit = 0;
        for (int i = 0; i < 4 * FRAME && !hit; i++) begin
            if (m_phase == p) hit = 1;
            else @(negedge clk);
        end
        if (!hit) begin
            checks++;
            failures++;
            $display("FAIL wait_phase timeout phase=%0d", p);
        end
    endtask

    task automatic do_load(input logic [4*N-1:0] v, input logic [N-1:0] d);
        value = v; dp_in = d; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; load = 1'b0; value = '0; dp_in = '0; lzb = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * FRAME + 3) @(negedge clk);          // plain scan order

        wait_phase(5);  do_load(16'h1234, 4'b0100);    // decode + dp
        repeat (2 * FRAME) @(negedge clk);

        pulse_reset();                                 // atomic commit from zeros
        wait_phase(6);  do_load(16'h1234, 4'b0000);
        repeat (2 * FRAME) @(negedge clk);

        lzb = 1'b1;                                    // load on the wrap edge
        wait_phase(FRAME - 1); do_load(16'h0005, 4'b0000);
        repeat (2 * FRAME) @(negedge clk);

        wait_phase(2); do_load(16'h1234, 4'b0000);     // repeated loads, last wins
        do_load(16'h0070, 4'b0010);
        repeat (2 * FRAME) @(negedge clk);

        lzb = 1'b0;
        wait_phase(9); do_load(16'hABCD, 4'b1111);     // hex codes
        repeat (2 * FRAME) @(negedge clk);

        wait_phase(3); do_load(16'h9999, 4'b1010);     // reset mid-pending
        wait_phase(10); pulse_reset();
        repeat (2 * FRAME) @(negedge clk);

        for (int c = 0; c < 3000; c++) begin
            logic [4*N-1:0] v;
            v = 16'($urandom);
            // Bias toward leading zeros so blanking is exercised
            case ($urandom_range(3))
                0: v = v & 16'h000F;
                1: v = v & 16'h00FF;
                2: v = v & 16'h0FFF;
                default: ;
            endcase
            value = v;
            dp_in = N'($urandom);
            load  = ($urandom_range(7) == 0);
            if ($urandom_range(15) == 0) lzb = ~lzb;
            rst_n = ($urandom_range(249) != 0);
            @(negedge clk);
        end
        load = 1'b0; rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
